// File: rtl/data_reg_write_sequencer.sv
// Buffered register-file write sequencer: FIFO of {addr, data} drained one per cycle into a
// registered one-hot write enable. Optional build macro: WR_BYPASS_EN (empty-FIFO bypass).
module data_reg_write_sequencer #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3,
    parameter int NUM_REGS   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          hold_i,
    output logic [NUM_REGS-1:0]           reg_we,
    output logic [DATA_W-1:0]             reg_wdata,
    output logic                          err_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [ADDR_W:0]    NUM_REGS_V = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [LVL_W-1:0]   DEPTH_V    = LVL_W'(FIFO_DEPTH);

    // Illegal addresses decode to an all-zero enable.
    function automatic logic [NUM_REGS-1:0] decode_onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] vec;
        for (int i = 0; i < NUM_REGS; i++) begin
            vec[i] = (addr == ADDR_W'(i));
        end
        return vec;
    endfunction

    function automatic logic addr_illegal(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} >= NUM_REGS_V);
    endfunction

    logic [ENT_W-1:0]    mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [LVL_W-1:0]    level_r;
    logic [LVL_W-1:0]    level_next_s;
    logic [NUM_REGS-1:0] reg_we_r;
    logic [DATA_W-1:0]   reg_wdata_r;
    logic                err_r;

    logic                wr_ready_s;
    logic                push_s;
    logic                fifo_push_s;
    logic                pop_s;
    logic                bypass_s;
    logic                issue_s;
    logic [ADDR_W-1:0]   issue_addr_s;
    logic [DATA_W-1:0]   issue_data_s;
    logic [ENT_W-1:0]    head_s;

    // No pass-through when full: ready depends only on current occupancy.
    assign wr_ready_s  = rst_n & (level_r < DEPTH_V);
    assign push_s      = wr_valid & wr_ready_s;
    assign pop_s       = (level_r != {LVL_W{1'b0}}) & ~hold_i;
    assign head_s      = mem_r[rd_ptr_r];

`ifdef WR_BYPASS_EN
    assign bypass_s    = push_s & (level_r == {LVL_W{1'b0}}) & ~hold_i;
`else
    assign bypass_s    = 1'b0;
`endif

    assign fifo_push_s = push_s & ~bypass_s;

    // Select the write to issue this edge: FIFO head first, bypass only when empty.
    always_comb begin
        issue_s      = 1'b0;
        issue_addr_s = head_s[ENT_W-1:DATA_W];
        issue_data_s = head_s[DATA_W-1:0];
        if (pop_s) begin
            issue_s      = 1'b1;
            issue_addr_s = head_s[ENT_W-1:DATA_W];
            issue_data_s = head_s[DATA_W-1:0];
        end else if (bypass_s) begin
            issue_s      = 1'b1;
            issue_addr_s = wr_addr;
            issue_data_s = wr_data;
        end else begin
            issue_s      = 1'b0;
        end
    end

    // Occupancy update for push/pop combinations.
    always_comb begin
        level_next_s = level_r;
        case ({fifo_push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_W'(1);
            2'b01:   level_next_s = level_r - LVL_W'(1);
            default: level_next_s = level_r;
        endcase
    end

    // FIFO storage; entries are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (fifo_push_s) begin
            mem_r[wr_ptr_r] <= {wr_addr, wr_data};
        end
    end

    // Pointers and occupancy; reset discards every pending write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (fifo_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r <= level_next_s;
        end
    end

    // Registered write port towards the register bank; wdata holds between writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_we_r    <= {NUM_REGS{1'b0}};
            reg_wdata_r <= {DATA_W{1'b0}};
            err_r       <= 1'b0;
        end else if (issue_s) begin
            reg_we_r    <= decode_onehot(issue_addr_s);
            reg_wdata_r <= issue_data_s;
            err_r       <= addr_illegal(issue_addr_s);
        end else begin
            reg_we_r    <= {NUM_REGS{1'b0}};
            err_r       <= 1'b0;
        end
    end

    assign wr_ready  = wr_ready_s;
    assign reg_we    = reg_we_r;
    assign reg_wdata = reg_wdata_r;
    assign err_o     = err_r;
    assign level_o   = level_r;

endmodule
